cpu_core_gen: RTL and testbench

Parametrised successor to the team's 8-bit LED-matrix CPU. Executes the same register-machine instruction set on a DW-bit datapath. Adds:
- a request/valid instruction-fetch handshake, so instruction memory may have wait states;
- correct carry generation, plus a JC instruction;
- 8-bit immediates, and HLT;
- run/single-step control.

Sits between the instruction ROM/BRAM and the 8-row LED matrix. Internally time-multiplexes the eight registers onto the matrix.

---
 rtl/cpu_core_gen.sv | 113 +++++++++++
 tb/tb_cpu_core_gen.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_core_gen.sv
// cpu_core_gen: DW-bit register CPU with handshaked instruction fetch, run/step control and 8-row LED scan (ports: clk, rst_n, run, step, imem_req/addr/rdata/valid, row, col, led, halted)
module cpu_core_gen #(
  parameter int DW = 8,
  parameter int PCW = 11,
  parameter int SCAN_DIV = 13
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           run,
  input  logic           step,
  output logic           imem_req,
  output logic [PCW-1:0] imem_addr,
  input  logic [15:0]    imem_rdata,
  input  logic           imem_valid,
  output logic [DW-1:0]  row,
  output logic [7:0]     col,
  output logic [3:0]     led,
  output logic           halted
);
  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;
  state_t state;
  logic [DW-1:0] regs [8];
  logic [PCW-1:0] pc, pc_inc, pc_nxt, tgt;
  logic [15:0] ir;
  logic c, c_nxt, step_q, wr_en, is_hlt;
  logic [SCAN_DIV+2:0] scan_cnt;
  logic [2:0] s, wr_idx, scan_i;
  logic [4:0] op;
  logic [DW-1:0] imm, rs, r0, wr_val;
  logic [DW:0] add_sum, inc_sum;
  assign op = ir[7:3];
  assign s = ir[2:0];
  assign imm = DW'(ir[15:8]);
  assign tgt = PCW'(ir[15:8]);
  assign rs = regs[s];
  assign r0 = regs[0];
  assign pc_inc = pc + 1'b1;
  assign add_sum = {1'b0, r0} + {1'b0, rs};
  assign inc_sum = {1'b0, rs} + 1'b1;
  assign is_hlt = op == 5'b11111;
  assign imem_addr = pc;
  assign led = {run, halted, imem_req, c};
  assign scan_i = scan_cnt[SCAN_DIV+2:SCAN_DIV];
  assign col = ~(8'h80 >> scan_i);
  always_comb begin
    row = '0;
    for (int k = 0; k < DW; k++) row[DW-1-k] = regs[scan_i][k];
  end
  always_comb begin
    wr_en = 1'b0;
    wr_idx = s;
    wr_val = rs;
    c_nxt = c;
    pc_nxt = pc_inc;
    if (op[4:3] == 2'b00) begin
      wr_en = 1'b1;
      wr_idx = op[2:0];
    end else begin
      case (op)
        5'b01000: begin wr_en = 1'b1; wr_idx = 3'd0; {c_nxt, wr_val} = add_sum; end
        5'b01001: begin wr_en = 1'b1; wr_idx = 3'd0; wr_val = r0 | rs; end
        5'b01010: begin wr_en = 1'b1; wr_idx = 3'd0; wr_val = r0 & rs; end
        5'b01011: begin wr_en = 1'b1; wr_idx = 3'd0; wr_val = r0 ^ rs; end
        5'b01100: begin wr_en = 1'b1; {c_nxt, wr_val} = inc_sum; end
        5'b01101: begin wr_en = 1'b1; wr_val = ~rs; end
        5'b01110: begin wr_en = 1'b1; wr_val = {rs[0], rs[DW-1:1]}; end
        5'b01111: begin wr_en = 1'b1; wr_val = {rs[DW-2:0], rs[DW-1]}; end
        5'b10000: begin pc_nxt = c ? pc_inc : tgt; c_nxt = 1'b0; end
        5'b10001: begin pc_nxt = c ? tgt : pc_inc; c_nxt = 1'b0; end
        5'b10010: pc_nxt = tgt;
        5'b10100: begin wr_en = 1'b1; wr_val = imm; end
        5'b11111: pc_nxt = pc;
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc <= '0;
      c <= 1'b0;
      ir <= '0;
      step_q <= 1'b0;
      scan_cnt <= '0;
      imem_req <= 1'b0;
      halted <= 1'b0;
      for (int k = 0; k < 8; k++) regs[k] <= '0;
    end else begin
      step_q <= step;
      scan_cnt <= scan_cnt + 1'b1;
      case (state)
        IDLE: if (run || (step && !step_q)) begin
          state <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: if (imem_valid) begin
          ir <= imem_rdata;
          state <= EXEC;
          imem_req <= 1'b0;
        end
        EXEC: begin
          if (wr_en) regs[wr_idx] <= wr_val;
          c <= c_nxt;
          pc <= pc_nxt;
          state <= is_hlt ? HALT : run ? FETCH : IDLE;
          imem_req <= run && !is_hlt;
          halted <= is_hlt;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_core_gen.sv
// tb_cpu_core_gen: randomized self-checking bench for cpu_core_gen against a behavioural ISA model
module tb_cpu_core_gen;
  logic clk = 0, rst_n = 0;
  logic run_a = 0, step_a = 0, imem_valid_a = 0, imem_req_a, halted_a;
  logic [7:0] imem_addr_a, row_a, col_a;
  logic [15:0] imem_rdata_a = 0;
  logic [3:0] led_a;
  logic run_b = 0, step_b = 0, imem_valid_b = 0, imem_req_b, halted_b;
  logic [3:0] imem_addr_b, led_b;
  logic [11:0] row_b;
  logic [7:0] col_b;
  logic [15:0] imem_rdata_b = 0;
  logic [15:0] mem_a [256];
  logic [15:0] mem_b [16];
  logic [7:0] got_a [8];
  int wait_a = 0, cnt_a = 0, n_tests = 0, n_fail = 0;
  int m_r [8];
  int m_pc, m_c, m_n, cyc_a, bad_hold;

  cpu_core_gen #(.DW(8), .PCW(8), .SCAN_DIV(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .run(run_a), .step(step_a),
    .imem_req(imem_req_a), .imem_addr(imem_addr_a), .imem_rdata(imem_rdata_a), .imem_valid(imem_valid_a),
    .row(row_a), .col(col_a), .led(led_a), .halted(halted_a));

  cpu_core_gen #(.DW(12), .PCW(4), .SCAN_DIV(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .run(run_b), .step(step_b),
    .imem_req(imem_req_b), .imem_addr(imem_addr_b), .imem_rdata(imem_rdata_b), .imem_valid(imem_valid_b),
    .row(row_b), .col(col_b), .led(led_b), .halted(halted_b));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // instruction memories: A has wait_a wait states per fetch, B is zero-wait
  initial forever begin
    @(negedge clk);
    if (imem_req_a) begin
      imem_valid_a = (cnt_a >= wait_a);
      imem_rdata_a = mem_a[imem_addr_a];
      cnt_a++;
    end else begin
      imem_valid_a = 0;
      cnt_a = 0;
    end
    imem_valid_b = imem_req_b;
    imem_rdata_b = mem_b[imem_addr_b];
  end

  function automatic logic [15:0] enc(input int op, input int s, input int imm);
    return {imm[7:0], op[4:0], s[2:0]};
  endfunction

  task automatic clear_mem_a;
    for (int a = 0; a < 256; a++) mem_a[a] = enc(31, 0, 0);
  endtask

  task automatic do_reset;
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic read_regs_a;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      for (int i = 0; i < 8; i++)
        if (col_a[7-i] == 1'b0)
          for (int k = 0; k < 8; k++) got_a[i][k] = row_a[7-k];
    end
  endtask

  task automatic model_a;
    int w, op, s, imm, rs, sum;
    for (int k = 0; k < 8; k++) m_r[k] = 0;
    m_pc = 0; m_c = 0; m_n = 0;
    for (int t = 0; t < 100; t++) begin
      w = mem_a[m_pc];
      op = (w >> 3) & 31; s = w & 7; imm = (w >> 8) & 255; rs = m_r[s];
      m_n++;
      if (op == 31) break;
      m_pc = (m_pc + 1) % 256;
      if (op < 8) m_r[op] = rs;
      else case (op)
        8: begin sum = m_r[0] + rs; m_c = sum > 255; m_r[0] = sum % 256; end
        9: m_r[0] = m_r[0] | rs;
        10: m_r[0] = m_r[0] & rs;
        11: m_r[0] = m_r[0] ^ rs;
        12: begin sum = rs + 1; m_c = sum > 255; m_r[s] = sum % 256; end
        13: m_r[s] = 255 - rs;
        14: m_r[s] = (rs >> 1) | ((rs & 1) << 7);
        15: m_r[s] = ((rs << 1) & 255) | (rs >> 7);
        16: begin if (m_c == 0) m_pc = imm; m_c = 0; end
        17: begin if (m_c != 0) m_pc = imm; m_c = 0; end
        18: m_pc = imm;
        20: m_r[s] = imm;
        default: ;
      endcase
    end
  endtask

  // random straight-line program of 12 words plus HLT; jumps only go forward
  task automatic gen_prog_a;
    int kind, op;
    clear_mem_a;
    for (int a = 0; a < 12; a++) begin
      kind = $urandom_range(0, 15);
      op = kind == 0 ? $urandom_range(0, 7) : kind <= 8 ? kind + 7 : kind == 10 ? 16 :
           kind == 11 ? 17 : kind == 12 ? 18 : kind == 13 ? 19 : 20;
      mem_a[a] = (op >= 16 && op <= 18) ? enc(op, $urandom_range(0, 7), a + 1 + $urandom_range(0, 11 - a))
                                       : enc(op, $urandom_range(0, 7), $urandom_range(0, 255));
    end
  endtask

  // runs mem_a free from reset until halted; tracks fetch request length and address stability
  task automatic run_a_prog(input int w);
    int len, pa;
    logic pr;
    wait_a = w; run_a = 1;
    do_reset;
    cyc_a = -1; bad_hold = 0; len = 0; pr = 0; pa = 0;
    for (int k = 1; k <= 3000; k++) begin
      @(negedge clk);
      if (imem_req_a) begin
        if (pr && imem_addr_a != pa) bad_hold++;
        len++;
        pa = imem_addr_a;
      end else if (pr) begin
        if (len != w + 1) bad_hold++;
        len = 0;
      end
      pr = imem_req_a;
      if (halted_a) begin cyc_a = k; break; end
    end
    read_regs_a;
  endtask

  task automatic test_reset;
    run_a = 1; rst_n = 0;
    @(negedge clk);
    n_tests++; if (imem_req_a !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b exp 0", imem_req_a); end
    n_tests++; if (imem_addr_a !== 8'h00) begin n_fail++; $display("FAIL reset_addr got %h exp 00", imem_addr_a); end
    n_tests++; if (halted_a !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %b exp 0", halted_a); end
    n_tests++; if (led_a !== 4'b1000) begin n_fail++; $display("FAIL reset_led got %b exp 1000", led_a); end
    n_tests++; if (row_a !== 8'h00) begin n_fail++; $display("FAIL reset_row got %h exp 00", row_a); end
    n_tests++; if (col_a !== 8'h7F) begin n_fail++; $display("FAIL reset_col got %h exp 7f", col_a); end
    run_a = 0;
  endtask

  task automatic test_jc_program;
    clear_mem_a;
    mem_a[0] = enc(20, 0, 255); mem_a[1] = enc(12, 0, 0); mem_a[2] = enc(17, 0, 5);
    mem_a[3] = enc(20, 0, 8'h55); mem_a[4] = enc(20, 0, 8'h55);
    wait_a = 0; run_a = 1;
    do_reset;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 5) begin
        n_tests++; if (led_a[0] !== 1'b1) begin n_fail++; $display("FAIL jc_carry_before got %b exp 1", led_a[0]); end
      end
      if (k == 7) begin
        n_tests++; if (led_a[0] !== 1'b0) begin n_fail++; $display("FAIL jc_carry_after got %b exp 0", led_a[0]); end
        n_tests++; if (imem_addr_a !== 8'd5) begin n_fail++; $display("FAIL jc_target got %0d exp 5", imem_addr_a); end
      end
      if (k == 8) begin
        n_tests++; if (halted_a !== 1'b0) begin n_fail++; $display("FAIL jc_halt_early got %b exp 0", halted_a); end
      end
      if (k == 9) begin
        n_tests++; if (halted_a !== 1'b1) begin n_fail++; $display("FAIL jc_halt_time got %b exp 1", halted_a); end
      end
    end
    read_regs_a;
    n_tests++; if (got_a[0] !== 8'h00) begin n_fail++; $display("FAIL jc_r0 got %h exp 00", got_a[0]); end
  endtask

  task automatic test_carry;
    clear_mem_a;
    mem_a[0] = enc(20, 0, 8'h80); mem_a[1] = enc(20, 1, 8'h80); mem_a[2] = enc(8, 1, 0);
    mem_a[3] = enc(16, 0, 8'h10); mem_a[16] = enc(20, 2, 8'h77);
    wait_a = 0; run_a = 1;
    do_reset;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k == 7) begin
        n_tests++; if (led_a[0] !== 1'b1) begin n_fail++; $display("FAIL add_carry got %b exp 1", led_a[0]); end
      end
      if (k == 9) begin
        n_tests++; if (led_a[0] !== 1'b0) begin n_fail++; $display("FAIL jnc_clear got %b exp 0", led_a[0]); end
        n_tests++; if (imem_addr_a !== 8'd4) begin n_fail++; $display("FAIL jnc_not_taken got %0d exp 4", imem_addr_a); end
      end
    end
    n_tests++; if (halted_a !== 1'b1) begin n_fail++; $display("FAIL carry_halt got %b exp 1", halted_a); end
    read_regs_a;
    n_tests++; if (got_a[0] !== 8'h00) begin n_fail++; $display("FAIL add_r0 got %h exp 00", got_a[0]); end
    n_tests++; if (got_a[1] !== 8'h80) begin n_fail++; $display("FAIL add_r1 got %h exp 80", got_a[1]); end
    n_tests++; if (got_a[2] !== 8'h00) begin n_fail++; $display("FAIL jnc_skip_r2 got %h exp 00", got_a[2]); end
  endtask

  task automatic test_random;
    for (int p = 0; p < 6; p++) begin
      gen_prog_a;
      model_a;
      run_a_prog(0);
      n_tests++; if (cyc_a != 1 + 2 * m_n) begin n_fail++; $display("FAIL rand%0d_cycles got %0d exp %0d", p, cyc_a, 1 + 2 * m_n); end
      n_tests++; if (bad_hold != 0) begin n_fail++; $display("FAIL rand%0d_req_hold got %0d bad exp 0", p, bad_hold); end
      for (int k = 0; k < 8; k++) begin
        n_tests++; if (got_a[k] !== 8'(m_r[k])) begin n_fail++; $display("FAIL rand%0d_r%0d got %h exp %h", p, k, got_a[k], 8'(m_r[k])); end
      end
      n_tests++; if (led_a[0] !== m_c[0]) begin n_fail++; $display("FAIL rand%0d_c got %b exp %b", p, led_a[0], m_c[0]); end
      n_tests++; if (imem_addr_a !== 8'(m_pc)) begin n_fail++; $display("FAIL rand%0d_pc got %0d exp %0d", p, imem_addr_a, m_pc); end
    end
  endtask

  task automatic test_wait_states;
    for (int p = 0; p < 2; p++) begin
      gen_prog_a;
      model_a;
      run_a_prog(3);
      n_tests++; if (cyc_a != 1 + 5 * m_n) begin n_fail++; $display("FAIL wait%0d_cycles got %0d exp %0d", p, cyc_a, 1 + 5 * m_n); end
      n_tests++; if (bad_hold != 0) begin n_fail++; $display("FAIL wait%0d_req_hold got %0d bad exp 0", p, bad_hold); end
      for (int k = 0; k < 8; k++) begin
        n_tests++; if (got_a[k] !== 8'(m_r[k])) begin n_fail++; $display("FAIL wait%0d_r%0d got %h exp %h", p, k, got_a[k], 8'(m_r[k])); end
      end
      n_tests++; if (imem_addr_a !== 8'(m_pc)) begin n_fail++; $display("FAIL wait%0d_pc got %0d exp %0d", p, imem_addr_a, m_pc); end
    end
  endtask

  task automatic test_step;
    clear_mem_a;
    mem_a[0] = enc(20, 1, 1);
    for (int a = 1; a < 5; a++) mem_a[a] = enc(12, 1, 0);
    mem_a[5] = enc(31, 0, 0);
    wait_a = 0; run_a = 0;
    do_reset;
    repeat (3) @(negedge clk);
    step_a = 1;
    @(negedge clk);
    step_a = 0;
    n_tests++; if (imem_req_a !== 1'b1) begin n_fail++; $display("FAIL step_fetch got %b exp 1", imem_req_a); end
    @(negedge clk);
    n_tests++; if (imem_req_a !== 1'b0 || imem_addr_a !== 8'd0) begin n_fail++; $display("FAIL step_exec got req %b pc %0d exp 0 0", imem_req_a, imem_addr_a); end
    @(negedge clk);
    n_tests++; if (imem_addr_a !== 8'd1) begin n_fail++; $display("FAIL step_commit got %0d exp 1", imem_addr_a); end
    repeat (2) begin
      step_a = 1;
      repeat (3) @(negedge clk);
      step_a = 0;
      repeat (3) @(negedge clk);
    end
    read_regs_a;
    n_tests++; if (got_a[1] !== 8'd3) begin n_fail++; $display("FAIL step3_r1 got %0d exp 3", got_a[1]); end
    n_tests++; if (imem_addr_a !== 8'd3) begin n_fail++; $display("FAIL step3_pc got %0d exp 3", imem_addr_a); end
    wait_a = 4;
    step_a = 1;
    @(negedge clk);
    step_a = 0;
    @(negedge clk);
    n_tests++; if (imem_req_a !== 1'b1) begin n_fail++; $display("FAIL step_wait_fetch got %b exp 1", imem_req_a); end
    step_a = 1;
    @(negedge clk);
    step_a = 0;
    repeat (12) @(negedge clk);
    read_regs_a;
    n_tests++; if (got_a[1] !== 8'd4) begin n_fail++; $display("FAIL step_ignored_r1 got %0d exp 4", got_a[1]); end
    n_tests++; if (imem_addr_a !== 8'd4) begin n_fail++; $display("FAIL step_ignored_pc got %0d exp 4", imem_addr_a); end
    n_tests++; if (halted_a !== 1'b0) begin n_fail++; $display("FAIL step_halted got %b exp 0", halted_a); end
  endtask

  task automatic test_halt_reset;
    int req_seen, found;
    clear_mem_a;
    mem_a[0] = enc(20, 0, 255); mem_a[1] = enc(8, 0, 0); mem_a[2] = enc(19, 0, 0);
    run_a_prog(0);
    n_tests++; if (led_a !== 4'b1101) begin n_fail++; $display("FAIL halt_led got %b exp 1101", led_a); end
    n_tests++; if (imem_addr_a !== 8'd3) begin n_fail++; $display("FAIL halt_pc got %0d exp 3", imem_addr_a); end
    req_seen = 0;
    for (int k = 0; k < 30; k++) begin
      step_a = k[1];
      run_a = k[2];
      @(negedge clk);
      if (imem_req_a !== 1'b0) req_seen++;
    end
    step_a = 0;
    n_tests++; if (req_seen != 0) begin n_fail++; $display("FAIL halt_no_req got %0d req cycles exp 0", req_seen); end
    n_tests++; if (halted_a !== 1'b1) begin n_fail++; $display("FAIL halt_absorb got %b exp 1", halted_a); end
    wait_a = 2; run_a = 1;
    do_reset;
    found = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (imem_req_a && imem_addr_a == 8'd2) begin found = 1; break; end
    end
    n_tests++; if (found == 0) begin n_fail++; $display("FAIL midfetch_reach got timeout exp fetch of 2"); end
    rst_n = 0;
    #1;
    n_tests++; if (imem_req_a !== 1'b0) begin n_fail++; $display("FAIL midfetch_req got %b exp 0", imem_req_a); end
    n_tests++; if (imem_addr_a !== 8'd0) begin n_fail++; $display("FAIL midfetch_addr got %0d exp 0", imem_addr_a); end
    n_tests++; if (led_a !== 4'b1000) begin n_fail++; $display("FAIL midfetch_led got %b exp 1000", led_a); end
    n_tests++; if (row_a !== 8'h00 || col_a !== 8'h7F) begin n_fail++; $display("FAIL midfetch_scan got %h/%h exp 00/7f", row_a, col_a); end
    n_tests++; if (halted_a !== 1'b0) begin n_fail++; $display("FAIL midfetch_halted got %b exp 0", halted_a); end
    run_a = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    read_regs_a;
    n_tests++; if (got_a[0] !== 8'h00) begin n_fail++; $display("FAIL midfetch_r0 got %h exp 00", got_a[0]); end
  endtask

  task automatic test_scan_width;
    logic [11:0] r3, r2;
    for (int a = 0; a < 16; a++) mem_b[a] = enc(19, 0, 0);
    mem_b[0] = enc(20, 3, 1); mem_b[1] = enc(20, 2, 8'hAB);
    run_a = 0; run_b = 1;
    do_reset;
    for (int k = 1; k <= 33; k++) begin
      @(posedge clk);
      #1;
      if (k == 31) begin
        n_tests++; if (imem_addr_b !== 4'hF || imem_req_b !== 1'b1) begin n_fail++; $display("FAIL b_pc_top got %h req %b exp f 1", imem_addr_b, imem_req_b); end
      end
      if (k == 33) begin
        n_tests++; if (imem_addr_b !== 4'h0 || imem_req_b !== 1'b1) begin n_fail++; $display("FAIL b_pc_wrap got %h req %b exp 0 1", imem_addr_b, imem_req_b); end
      end
    end
    run_b = 0;
    repeat (4) @(negedge clk);
    r3 = 'x; r2 = 'x;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (col_b == 8'hEF) r3 = row_b;
      if (col_b == 8'hDF) r2 = row_b;
    end
    n_tests++; if (r3 !== 12'h800) begin n_fail++; $display("FAIL b_row3 got %h exp 800", r3); end
    n_tests++; if (r2 !== 12'hD50) begin n_fail++; $display("FAIL b_row2 got %h exp d50", r2); end
  endtask

  initial begin
    clear_mem_a;
    for (int a = 0; a < 16; a++) mem_b[a] = enc(19, 0, 0);
    test_reset;
    test_jc_program;
    test_carry;
    test_random;
    test_wait_states;
    test_step;
    test_halt_reset;
    test_scan_width;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
